// File: rtl/poly8_mul_acc_pipe.sv
// rtl/poly8_mul_acc_pipe.sv - pipelined signed multiplier with optional in-place accumulate
module poly8_mul_acc_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 40
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  din_vld,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_vld,
  output logic                  ovf
);

  localparam int PW = din0_WIDTH + din1_WIDTH;

  logic w_unused_id;
  assign w_unused_id = (ID != 0);

  // Operands are sign-extended to the full product width so the PW-bit product is exact.
  logic signed [PW-1:0] w_op0;
  logic signed [PW-1:0] w_op1;
  logic signed [PW-1:0] w_prod;
  assign w_op0  = {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0};
  assign w_op1  = {{din0_WIDTH{din1[din1_WIDTH-1]}}, din1};
  assign w_prod = w_op0 * w_op1;

  logic [PW-1:0] w_fin_prod;
  logic          w_fin_vld;
  logic          w_fin_acc_en;
  logic          w_fin_acc_clr;

  generate
    if (NUM_STAGE > 1) begin : g_pipe
      logic [PW-1:0]        r_prod [NUM_STAGE-1];
      logic [NUM_STAGE-2:0] r_vld;
      logic [NUM_STAGE-2:0] r_acc_en;
      logic [NUM_STAGE-2:0] r_acc_clr;

      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
          for (int i = 0; i < NUM_STAGE-1; i++) begin
            r_prod[i] <= '0;
          end
          r_vld     <= '0;
          r_acc_en  <= '0;
          r_acc_clr <= '0;
        end else if (ce) begin
          r_prod[0]    <= w_prod;
          r_vld[0]     <= din_vld;
          r_acc_en[0]  <= acc_en;
          r_acc_clr[0] <= acc_clr;
          for (int i = 1; i < NUM_STAGE-1; i++) begin
            r_prod[i]    <= r_prod[i-1];
            r_vld[i]     <= r_vld[i-1];
            r_acc_en[i]  <= r_acc_en[i-1];
            r_acc_clr[i] <= r_acc_clr[i-1];
          end
        end
      end

      assign w_fin_prod    = r_prod[NUM_STAGE-2];
      assign w_fin_vld     = r_vld[NUM_STAGE-2];
      assign w_fin_acc_en  = r_acc_en[NUM_STAGE-2];
      assign w_fin_acc_clr = r_acc_clr[NUM_STAGE-2];
    end else begin : g_direct
      assign w_fin_prod    = w_prod;
      assign w_fin_vld     = din_vld;
      assign w_fin_acc_en  = acc_en;
      assign w_fin_acc_clr = acc_clr;
    end
  endgenerate

  logic [dout_WIDTH-1:0] w_fin_ext;
  generate
    if (dout_WIDTH > PW) begin : g_sext
      assign w_fin_ext = {{(dout_WIDTH-PW){w_fin_prod[PW-1]}}, w_fin_prod};
    end else begin : g_nosext
      assign w_fin_ext = w_fin_prod;
    end
  endgenerate

  logic [dout_WIDTH-1:0] r_dout;
  logic                  r_dout_vld;
  logic                  r_ovf;
  logic [dout_WIDTH-1:0] w_sum;
  logic                  w_add_ovf;
  logic                  w_accum;

  // Signed overflow: same-sign operands whose wrapped sum changes sign.
  assign w_sum     = r_dout + w_fin_ext;
  assign w_add_ovf = (r_dout[dout_WIDTH-1] == w_fin_ext[dout_WIDTH-1]) &&
                     (w_sum[dout_WIDTH-1] != r_dout[dout_WIDTH-1]);
  assign w_accum   = w_fin_acc_en & ~w_fin_acc_clr;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (ce) begin
      r_dout_vld <= w_fin_vld;
      if (w_fin_vld) begin
        if (w_accum) begin
          r_dout <= w_sum;
          if (w_add_ovf) begin
            r_ovf <= 1'b1;
          end
        end else begin
          r_dout <= w_fin_ext;
          r_ovf  <= 1'b0;
        end
      end
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
  assign ovf      = r_ovf;

endmodule
